// File: rtl/wb_queue.sv
// rtl/wb_queue.sv - write-back queue feeding the one-hot register bank write port
//
// Buffers up to DEPTH pending register writes {addr, data} in a circular
// buffer and retires the oldest one per cycle into the register bank.
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous active-low reset
//   push_valid  producer has a write to enqueue
//   push_ready  queue not full (from current count only)
//   push_addr   destination register index
//   push_data   value to write
//   stall       hold the head entry, no bank write this cycle
//   chosen      one-hot register select of the head entry while popping
//   w_en        bank write strobe
//   w_data      head entry data while popping, else 0
//   pend_addr   register index queried by decode
//   pend_hit    some valid queued entry targets pend_addr
//   count       number of valid entries
//   err         sticky error: overflow, bad address or unknown push fields
module wb_queue #(
    parameter int DEPTH = 4,
    parameter int NREGS = 8,
    parameter int AW    = 3,
    parameter int DW    = 14
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_valid,
    output logic                       push_ready,
    input  logic [AW-1:0]              push_addr,
    input  logic [DW-1:0]              push_data,
    input  logic                       stall,
    output logic [NREGS-1:0]           chosen,
    output logic                       w_en,
    output logic [DW-1:0]              w_data,
    input  logic [AW-1:0]              pend_addr,
    output logic                       pend_hit,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [AW:0]   NREGS_LIM = (AW+1)'(NREGS);
    localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);

    logic [AW-1:0] mem_addr [DEPTH];
    logic [DW-1:0] mem_data [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    logic full;
    logic addr_ok;
    logic push_ok;
    logic pop;
    logic push_unknown;
    logic err_set;

    assign full       = (count == DEPTH_C);
    assign push_ready = ~full;
    assign addr_ok    = ({1'b0, push_addr} < NREGS_LIM);
    assign push_ok    = push_valid & ~full & addr_ok;
    assign pop        = (count != '0) & ~stall;

    // Only meaningful in a four-state simulator; hardware never sees X.
`ifdef SYNTHESIS
    assign push_unknown = 1'b0;
`else
    assign push_unknown = ((^{push_addr, push_data}) === 1'bx);
`endif

    assign err_set = push_valid & (full | ~addr_ok | push_unknown);

    // Bank write port: driven only while an entry is actually retiring.
    assign w_en   = pop;
    assign w_data = pop ? mem_data[rd_ptr] : '0;

    always_comb begin
        chosen = '0;
        if (pop) begin
            chosen[mem_addr[rd_ptr]] = 1'b1;
        end
    end

    // An entry i is valid when its distance from the read pointer (modulo
    // DEPTH) is below count; the head is included even while it pops.
    always_comb begin
        pend_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (({1'b0, PW'(i) - rd_ptr} < count) && (mem_addr[i] == pend_addr)) begin
                pend_hit = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            err    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_addr[i] <= '0;
                mem_data[i] <= '0;
            end
        end else begin
            if (push_ok) begin
                mem_addr[wr_ptr] <= push_addr;
                mem_data[wr_ptr] <= push_data;
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (err_set) begin
                err <= 1'b1;
            end
        end
    end

endmodule
